// File: rtl/arena_border_pkg.sv
// Shared arena geometry, pixel colour type and border FSM states.
// Pure declarations: no latency, no flow control.
// The renderer is free-running, so no backpressure applies.
package arena_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHRINK = 2'd1,
    HOLD   = 2'd2
  } border_state_t;

endpackage

// File: rtl/arena_border_range_check.sv
// Half-open interval test: hit when lo <= value < hi.
// Combinational, zero latency.
// No flow control.
module range_check (
  input  logic [11:0] value,
  input  logic [11:0] lo,
  input  logic [11:0] hi,
  output logic        hit
);

  assign hit = (value >= lo) && (value < hi);

endmodule

// File: rtl/arena_border.sv
// Arena wall renderer with shrinking-inset FSM; flash colour under ARENA_BORDER_FLASH_EN.
// Latency: RGB and in_border are registered, 1 cycle after row/col.
// Free-running pixel stream, no backpressure.
module arena_border
  import arena_pkg::*;
#(
  parameter int   LEFT_W          = 105,
  parameter int   RIGHT_W         = 104,
  parameter int   TOP_W           = 5,
  parameter int   BOTTOM_W        = 4,
  parameter int   STEP            = 4,
  parameter int   FRAMES_PER_STEP = 60,
  parameter int   MAX_INSET       = 200,
  parameter rgb_t BORDER_RGB      = 24'hFFFFFF,
  parameter rgb_t FLASH_RGB       = 24'hFF0000,
  parameter int   FLASH_FRAMES    = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic       frame_tick,
  input  logic       shrink_go,
  input  logic       restart,
  input  logic       flash_req,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       in_border,
  output logic [7:0] inset,
  output logic       shrinking
);

  localparam int FC_W = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [11:0] H12 = 12'(H_ACTIVE);
  localparam logic [11:0] V12 = 12'(V_ACTIVE);

  border_state_t state;
  logic [FC_W-1:0] frame_cnt;
  logic [7:0]      inset_next;

  assign inset_next = inset + 8'(STEP);

  // restart has priority over everything so a reset-to-static is always clean
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      inset     <= '0;
      frame_cnt <= '0;
      shrinking <= 1'b0;
    end else if (restart) begin
      state     <= IDLE;
      inset     <= '0;
      frame_cnt <= '0;
      shrinking <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (shrink_go) begin
            state     <= SHRINK;
            frame_cnt <= '0;
            shrinking <= 1'b1;
          end
        end
        SHRINK: begin
          if (frame_tick) begin
            if (frame_cnt == FC_W'(FRAMES_PER_STEP - 1)) begin
              frame_cnt <= '0;
              inset     <= inset_next;
              if (inset_next == 8'(MAX_INSET)) begin
                state     <= HOLD;
                shrinking <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        HOLD: ;
        default: begin
          state     <= IDLE;
          shrinking <= 1'b0;
        end
      endcase
    end
  end

  rgb_t cur_rgb;

`ifdef ARENA_BORDER_FLASH_EN
  localparam int FL_W = $clog2(FLASH_FRAMES + 1);
  logic [FL_W-1:0] flash_cnt;
  logic            flash_phase;

  always_ff @(posedge clock) begin
    if (!reset || restart) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (flash_req) begin
      flash_cnt   <= FL_W'(FLASH_FRAMES);
      flash_phase <= 1'b0;
    end else if (frame_tick && flash_cnt != '0) begin
      flash_cnt   <= flash_cnt - 1'b1;
      flash_phase <= ~flash_phase;
    end
  end

  assign cur_rgb = (flash_phase && flash_cnt != '0) ? FLASH_RGB : BORDER_RGB;
`else
  localparam int unused_flash_cfg = FLASH_FRAMES + int'(FLASH_RGB.r);
  logic unused_flash_req;
  assign unused_flash_req = flash_req;
  assign cur_rgb = BORDER_RGB;
`endif

  // All side bounds are formed in 12 bits so inset growth can never wrap.
  logic [11:0] col_w, row_w, inset_w;
  logic [11:0] right_span, bottom_span, right_lo, bottom_lo;
  logic        hit_l, hit_r, hit_t, hit_b;

  assign col_w       = {2'b00, col};
  assign row_w       = {2'b00, row};
  assign inset_w     = {4'b0000, inset};
  assign right_span  = 12'(RIGHT_W) + inset_w;
  assign bottom_span = 12'(BOTTOM_W) + inset_w;
  assign right_lo    = (right_span >= H12) ? 12'd0 : H12 - right_span;
  assign bottom_lo   = (bottom_span >= V12) ? 12'd0 : V12 - bottom_span;

  range_check u_left   (.value(col_w), .lo(12'd0),     .hi(12'(LEFT_W) + inset_w), .hit(hit_l));
  range_check u_right  (.value(col_w), .lo(right_lo),  .hi(H12),                   .hit(hit_r));
  range_check u_top    (.value(row_w), .lo(12'd0),     .hi(12'(TOP_W) + inset_w),  .hit(hit_t));
  range_check u_bottom (.value(row_w), .lo(bottom_lo), .hi(V12),                   .hit(hit_b));

  logic visible, wall;
  assign visible = (col_w < H12) && (row_w < V12);
  assign wall    = visible && (hit_l || hit_r || hit_t || hit_b);

  rgb_t pix;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pix       <= '0;
      in_border <= 1'b0;
    end else begin
      pix       <= wall ? cur_rgb : rgb_t'('0);
      in_border <= wall;
    end
  end

  assign red   = pix.r;
  assign green = pix.g;
  assign blue  = pix.b;

endmodule
